// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: state encoding and framing constants.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 868;  // 100 MHz / 115200 baud
  localparam int UART_DATA_BITS       = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO: head presented combinationally, drops pushes when full unless a pop frees a slot.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic             overrun
);

  localparam int AW = $clog2(DEPTH);

  // Extra MSB on each pointer tells full from empty when the index bits match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign overrun = push && full && !pop_ok;
  assign head    = mem[rd_ptr[AW-1:0]];

  // NOTE: the storage is reset on purpose so the head reads 8'h00 out of reset;
  // at this depth the cost is negligible. Larger FIFOs would leave RAM unreset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: synchronizer, mid-bit sampling FSM and a small receive FIFO.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun_err
);

  localparam int              CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]      LAST_IDX  = 3'(UART_DATA_BITS - 1);

  logic [1:0] sync_ff;
  logic       rx_s;
  logic       rx_prev;
  logic [1:0] warm;
  logic       armed;
  logic       fall;

  rx_state_e                 state, state_next;
  logic [CW-1:0]             cnt, cnt_next;
  logic [2:0]                bit_idx, bit_idx_next;
  logic [UART_DATA_BITS-1:0] shreg, shreg_next;
  logic                      push;
  logic                      frame_err_next;
  logic                      fifo_empty;
  logic                      fifo_full;
  logic                      fifo_overrun;

  assign rx_s = sync_ff[1];

  // A line already low at reset release must not look like a start edge, so edge
  // detection is armed only once a real synchronized high has been observed.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_ff <= 2'b11;
      rx_prev <= 1'b1;
      warm    <= 2'b00;
      armed   <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[0], uart_rx};
      rx_prev <= rx_s;
      warm    <= {warm[0], 1'b1};
      if (warm[1] && rx_s) armed <= 1'b1;
    end
  end

  assign fall = armed && rx_prev && !rx_s;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt + 1'b1;
    bit_idx_next   = bit_idx;
    shreg_next     = shreg;
    push           = 1'b0;
    frame_err_next = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_next = '0;
        if (fall) state_next = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_next     = '0;
          bit_idx_next = '0;
          state_next   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_next   = '0;
          shreg_next = {rx_s, shreg[UART_DATA_BITS-1:1]};
          if (bit_idx == LAST_IDX) begin
            bit_idx_next = '0;
            state_next   = STOP;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        // Leaving at mid stop bit leaves half a bit to catch a back-to-back start edge.
        if (cnt == BIT_LAST) begin
          cnt_next       = '0;
          state_next     = IDLE;
          push           = rx_s;
          frame_err_next = !rx_s;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values computed above.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      bit_idx     <= bit_idx_next;
      shreg       <= shreg_next;
      frame_err   <= frame_err_next;
      overrun_err <= fifo_overrun;
    end
  end

  assign busy     = (state != IDLE);
  assign rx_valid = !fifo_empty;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .push_data (shreg),
    .pop       (rx_ready),
    .head      (rx_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .overrun   (fifo_overrun)
  );

endmodule
